// File: rtl/pmem_responder.sv
// Word-addressed memory responder: one read or byte-masked write outstanding, serviced from an internal array.
// Latency: response registered LATENCY edges after the accepting edge (visible one edge later); LATENCY=0 responds on the next cycle.
// Backpressure: response is held stable until rsp_ready; req_ready stays low from acceptance until one cycle after the response handshake.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_wen/req_addr/req_wdata/req_wmask : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                    : response channel
module pmem_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT   = 4'(LATENCY);
    // One past the last valid byte address; 33 bits so BASE near the top of the map cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);

    if (LATENCY > 15) begin : g_bad_latency
        $error("pmem_responder: LATENCY must be in 0..15");
    end
    if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pmem_responder: DEPTH must be a power of 2");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic        commit;
    logic        c_wen;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        in_range;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;

    assign accept = (state_q == IDLE) && req_ready_q && req_valid;
    // With zero latency the commit happens on the accepting edge itself,
    // so it must use the live request rather than the latched copy.
    assign commit = (accept && (LAT == 4'd0)) || ((state_q == WAIT) && (cnt_q == 4'd1));

    always_comb begin
        c_wen   = wen_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_wmask = wmask_q;
        if (state_q == IDLE) begin
            c_wen   = req_wen;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wmask = req_wmask;
        end
    end

    always_comb begin
        off         = c_addr - BASE;
        idx         = AW'(off >> 2);
        in_range    = ({1'b0, c_addr} >= {1'b0, BASE}) && ({1'b0, c_addr} < LIMIT);
        rsp_err_d   = ~in_range;
        rsp_rdata_d = 32'h0;
        if (in_range && !c_wen) begin
            rsp_rdata_d = mem_q[idx];
        end
    end

    // Array is not reset. commit is already low while rst is held, because the
    // control state is forced to IDLE with req_ready low.
    always_ff @(posedge clk) begin
        if (commit && c_wen && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wmask[i]) begin
                    mem_q[idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            cnt_q       <= 4'd0;
            wen_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        wen_q       <= req_wen;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wmask_q     <= req_wmask;
                        cnt_q       <= LAT;
                        req_ready_q <= 1'b0;
                        if (commit) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                            state_q     <= RESP;
                        end else begin
                            state_q     <= WAIT;
                        end
                    end else begin
                        // First edge out of reset raises ready.
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (commit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one instance at LATENCY=2 and one at LATENCY=4
// sharing the request/response stimulus; 'sel' picks which instance is addressed.
module tb_pmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst4, sel;
    logic        req_valid, req_wen, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;

    logic        rv2, rv4;
    logic        rr2, rr4, sv2, sv4, re2, re4;
    logic [31:0] rd2, rd4;

    assign rv2 = req_valid & ~sel;
    assign rv4 = req_valid & sel;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;
    assign req_ready_m = sel ? rr4 : rr2;
    assign rsp_valid_m = sel ? sv4 : sv2;
    assign rsp_err_m   = sel ? re4 : re2;
    assign rsp_rdata_m = sel ? rd4 : rd2;

    pmem_responder #(.DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst2),
        .req_valid(rv2), .req_ready(rr2), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(sv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2)
    );

    pmem_responder #(.DEPTH(4096), .BASE(32'h8000_0000), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst4),
        .req_valid(rv4), .req_ready(rr4), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(sv4), .rsp_ready(rsp_ready), .rsp_rdata(rd4), .rsp_err(re4)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge and hold it until accepted; returns at the
    // negedge right after the accepting edge with req_valid dropped.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask);
        int n = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!req_ready_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(req_ready_m), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full transaction with rsp_ready high. Counts negedges after the accepting
    // edge until rsp_valid is seen: registered at edge T+LATENCY, so LATENCY+1.
    task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [31:0] exp_rd, input logic exp_err);
        int   cyc;
        logic rdy_bad;
        int   lat_exp;
        lat_exp = sel ? 5 : 3;
        issue(wen, addr, wdata, wmask);
        cyc     = 1;
        rdy_bad = 1'b0;
        while (!rsp_valid_m && cyc < 40) begin
            if (req_ready_m) rdy_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (req_ready_m) rdy_bad = 1'b1;
        check({tag, ".lat"},     32'(cyc), 32'(lat_exp));
        check({tag, ".rdy_low"}, 32'(rdy_bad), 32'd0);
        check({tag, ".rdata"},   rsp_rdata_m, exp_rd);
        check({tag, ".err"},     32'(rsp_err_m), 32'(exp_err));
        @(negedge clk);
        check({tag, ".vld_clr"}, 32'(rsp_valid_m), 32'd0);
        check({tag, ".rd_clr"},  rsp_rdata_m, 32'd0);
        check({tag, ".rdy_set"}, 32'(req_ready_m), 32'd1);
    endtask

    logic [31:0] held_rd;
    logic        held_err;
    logic        held_ok;
    logic        rdy_leak;
    int          cyc;

    initial begin
        sel       = 1'b0;
        rst2      = 1'b0;
        rst4      = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wmask = 4'h0;
        rsp_ready = 1'b1;

        // Reset release
        repeat (3) @(negedge clk);
        check("rst.ready", 32'(req_ready_m), 32'd0);
        check("rst.valid", 32'(rsp_valid_m), 32'd0);
        check("rst.rdata", rsp_rdata_m, 32'd0);
        check("rst.err",   32'(rsp_err_m), 32'd0);
        rst2 = 1'b1;
        rst4 = 1'b1;
        #1;
        check("rel.ready_before_edge", 32'(req_ready_m), 32'd0);
        @(negedge clk);
        check("rel.ready_after_edge", 32'(req_ready_m), 32'd1);
        check("rel.valid", 32'(rsp_valid_m), 32'd0);

        // Preload and read latency
        txn("pre_wr",  1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn("rd0",     1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        txn("rd0_lo",  1'b0, 32'h8000_0003, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);

        // Masked write merge, then a zero-mask write that must not change anything
        txn("wr_full", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
        txn("wr_m5",   1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0101, 32'h0, 1'b0);
        txn("rd_merge",1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hFF34_FF78, 1'b0);
        txn("wr_m0",   1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
        txn("rd_m0",   1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hFF34_FF78, 1'b0);

        // Range edges
        txn("oor_rd",  1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1);
        txn("oor_wr",  1'b1, 32'h8000_4000, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
        txn("rd_after_oor", 1'b0, 32'h8000_0000, 32'h0,    4'h0, 32'hDEAD_BEEF, 1'b0);
        txn("last_wr", 1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        txn("last_rd", 1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);

        // Backpressure: response held while stray requests are presented
        rsp_ready = 1'b0;
        issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        cyc = 1;
        while (!rsp_valid_m && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("bp.lat",   32'(cyc), 32'd3);
        check("bp.rdata", rsp_rdata_m, 32'hFF34_FF78);
        held_rd  = rsp_rdata_m;
        held_err = rsp_err_m;
        held_ok  = 1'b1;
        rdy_leak = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            req_wen   = 1'b1;
            req_addr  = 32'h8000_0000;
            req_wdata = 32'h0;
            req_wmask = 4'hF;
            @(negedge clk);
            if (!rsp_valid_m || rsp_rdata_m !== held_rd || rsp_err_m !== held_err) held_ok = 1'b0;
            if (req_ready_m) rdy_leak = 1'b1;
        end
        req_valid = 1'b0;
        check("bp.held",     32'(held_ok), 32'd1);
        check("bp.rdy_low",  32'(rdy_leak), 32'd0);
        check("bp.err",      32'(held_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.vld_clr",  32'(rsp_valid_m), 32'd0);
        check("bp.rdy_set",  32'(req_ready_m), 32'd1);
        repeat (3) @(negedge clk);
        check("bp.no_stray", 32'(rsp_valid_m), 32'd0);
        txn("bp.rd0", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset mid-operation on the LATENCY=4 instance
        sel = 1'b1;
        txn("l4_old",  1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h8000_0020, 32'hAAAA_AAAA, 4'hF);
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("mid.ready_rst", 32'(req_ready_m), 32'd0);
        check("mid.valid_rst", 32'(rsp_valid_m), 32'd0);
        repeat (4) @(negedge clk);
        check("mid.valid_hold", 32'(rsp_valid_m), 32'd0);
        rst4 = 1'b1;
        @(negedge clk);
        check("mid.ready_rel", 32'(req_ready_m), 32'd1);
        repeat (6) @(negedge clk);
        check("mid.valid_rel", 32'(rsp_valid_m), 32'd0);
        txn("mid.rd", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1111_1111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
